// File: rtl/dice_monitor_if.sv
// Bus between a dice-display observer and whoever drives/reads it.
// The master side supplies the sampled display pins, clear and read select;
// the slave side (the monitor) returns the readout and roll status.
interface dice_monitor_if #(
    parameter int COUNT_W = 12
);
    logic [6:0]         seg_in;     // segment pattern, bit0=a .. bit6=g
    logic               dp_in;      // decimal point: low while rolling
    logic               clr;        // clear all counters
    logic [2:0]         rd_sel;     // 0=total, 1..6=face, 7=error
    logic [COUNT_W-1:0] rd_data;    // registered readout
    logic [2:0]         face_out;   // last committed face, 0 if invalid
    logic               roll_done;  // one-cycle commit pulse
    logic               busy;       // roll in progress

    modport master (
        output seg_in, dp_in, clr, rd_sel,
        input  rd_data, face_out, roll_done, busy
    );

    modport slave (
        input  seg_in, dp_in, clr, rd_sel,
        output rd_data, face_out, roll_done, busy
    );
endinterface

// File: rtl/dice_monitor.sv
// Observer for a 7-segment dice display. Synchronizes the segment and
// decimal-point pins, waits for the display to settle after the roll ends,
// decodes the shown face and keeps saturating roll histograms.
module dice_monitor #(
    parameter int COUNT_W    = 12,
    parameter int SETTLE_CYC = 16   // legal range 1..255
) (
    input  logic          wb_clk_i,
    input  logic          rst_n,
    dice_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [7:0]         STAB_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    state_t             state;
    state_t             state_nx;
    logic [6:0]         seg_m;
    logic [6:0]         seg_s;
    logic               dp_m;
    logic               dp_s;
    logic [6:0]         seg_q;
    logic [7:0]         stab_cnt;
    logic [2:0]         face_q;
    logic [2:0]         bump_idx;
    logic [COUNT_W-1:0] cnt [8];    // 0=total, 1..6=faces, 7=error
    logic [COUNT_W-1:0] rd_q;
    logic               roll_done;
    logic               busy;
    logic               seg_stable;
    logic               commit_entry;

    // Map a settled segment pattern (g..a, MSB first) to a face; 0 = invalid.
    function automatic logic [2:0] decode_face(input logic [6:0] seg);
        case (seg)
            7'b0000110: return 3'd1;
            7'b1011011: return 3'd2;
            7'b1001111: return 3'd3;
            7'b1100110: return 3'd4;
            7'b1101101: return 3'd5;
            7'b1111101: return 3'd6;
            default:    return 3'd0;
        endcase
    endfunction

    assign seg_stable   = (seg_s == seg_q);
    assign commit_entry = (state == SETTLE) && (state_nx == COMMIT);
    // Invalid commits are tallied in the error slot.
    assign bump_idx     = (face_q == 3'd0) ? 3'd7 : face_q;

    // Two-flop synchronizers; dp resets high so an idle display is not a roll.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: clocked state is always assigned with <= so every flop samples
        // the pre-edge values of the others, independent of statement order.
        if (!rst_n) begin
            seg_m <= '0;
            seg_s <= '0;
            dp_m  <= 1'b1;
            dp_s  <= 1'b1;
        end else begin
            seg_m <= bus.seg_in;
            seg_s <= seg_m;
            dp_m  <= bus.dp_in;
            dp_s  <= dp_m;
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: roll starts on dp low, settles once dp is high and
    // the segments hold still for SETTLE_CYC cycles.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nx
        // unassigned and infers a latch.
        state_nx = state;
        case (state)
            IDLE:    if (!dp_s) state_nx = ROLLING;
            ROLLING: if (dp_s)  state_nx = SETTLE;
            SETTLE: begin
                if (!dp_s)
                    state_nx = ROLLING;
                else if (seg_stable && stab_cnt == STAB_LAST)
                    state_nx = COMMIT;
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        roll_done = (state == COMMIT);
        busy      = (state == ROLLING) || (state == SETTLE);
    end

    // Stability tracker: restart the count whenever the pattern moves.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            seg_q    <= '0;
            stab_cnt <= '0;
        end else if (state == ROLLING && dp_s) begin
            seg_q    <= seg_s;
            stab_cnt <= '0;
        end else if (state == SETTLE && dp_s) begin
            if (!seg_stable) begin
                seg_q    <= seg_s;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    // Latch the decoded face on the way into COMMIT so it is valid alongside
    // roll_done; the pattern equals seg_q at that point.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n)            face_q <= 3'd0;
        else if (commit_entry) face_q <= decode_face(seg_s);
    end

    // Saturating histogram counters; clear overrides a coincident commit.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: these eight words are plain flops, not a RAM macro, so they
        // can and must be reset to read back 0 after reset.
        if (!rst_n || bus.clr) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else if (state == COMMIT) begin
            if (cnt[0] != CNT_MAX)        cnt[0]        <= cnt[0] + CNT_ONE;
            if (cnt[bump_idx] != CNT_MAX) cnt[bump_idx] <= cnt[bump_idx] + CNT_ONE;
        end
    end

    // Registered readout of the selected counter.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= cnt[bus.rd_sel];
    end

    assign bus.rd_data   = rd_q;
    assign bus.face_out  = face_q;
    assign bus.roll_done = roll_done;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_dice_monitor.sv
// Directed bench for dice_monitor: a default instance plus a COUNT_W=4
// instance fed from the same pins for the saturation checks.
module tb_dice_monitor;

    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_BAD = 7'b1111111;
    // dp driven 1 ns after edge 0; roll_done is high in cycle 20 counting
    // that cycle as 1, i.e. after the 19th following edge.
    localparam int         LAT     = 19;

    logic wb_clk_i = 1'b0;
    logic rst_n    = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    dice_monitor_if #(.COUNT_W(12)) bus ();
    dice_monitor_if #(.COUNT_W(4))  bus_s ();

    assign bus_s.seg_in = bus.seg_in;
    assign bus_s.dp_in  = bus.dp_in;
    assign bus_s.clr    = bus.clr;
    assign bus_s.rd_sel = bus.rd_sel;

    dice_monitor #(.COUNT_W(12), .SETTLE_CYC(16)) u_dut (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    dice_monitor #(.COUNT_W(4), .SETTLE_CYC(16)) u_dut_s (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .bus      (bus_s)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.dp_in  = 1'b1;
        bus.seg_in = SEG_1;
        bus.clr    = 1'b0;
        bus.rd_sel = 3'd0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic read_big(input string tag, input logic [2:0] sel, input int exp);
        bus.rd_sel = sel;
        step(2);
        check(tag, 32'(bus.rd_data), exp);
    endtask

    task automatic read_small(input string tag, input logic [2:0] sel, input int exp);
        bus.rd_sel = sel;
        step(2);
        check(tag, 32'(bus_s.rd_data), exp);
    endtask

    // Hold dp low long enough for the monitor to reach ROLLING.
    task automatic start_roll(input logic [6:0] seg);
        bus.dp_in  = 1'b0;
        bus.seg_in = seg;
        step(8);
    endtask

    // Step until roll_done (bounded) and check latency and face; returns in
    // the COMMIT cycle.
    task automatic wait_commit(input string tag, input int exp_steps, input logic [2:0] exp_face);
        int seen = 0;
        for (int i = 1; i <= 80 && seen == 0; i++) begin
            step(1);
            if (bus.roll_done === 1'b1) seen = i;
        end
        check({tag, "_latency"}, seen, exp_steps);
        check({tag, "_face"}, 32'(bus.face_out), 32'(exp_face));
    endtask

    task automatic end_commit(input string tag);
        step(1);
        check({tag, "_pulse_width"}, 32'(bus.roll_done), 0);
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (bus.roll_done === 1'b1) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;

        // Reset state, then an idle high dp must never count as a roll.
        do_reset();
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_face_out", 32'(bus.face_out), 0);
        check("rst_roll_done", 32'(bus.roll_done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        count_pulses(100, pulses);
        check("idle_no_commit", pulses, 0);
        check("idle_busy", 32'(bus.busy), 0);
        read_big("idle_total", 3'd0, 0);

        // Nominal roll landing on 5.
        bus.dp_in = 1'b0;
        step(20);
        check("rolling_busy", 32'(bus.busy), 1);
        bus.seg_in = SEG_5;
        bus.dp_in  = 1'b1;
        wait_commit("roll5", LAT, 3'd5);
        check("roll5_busy_in_commit", 32'(bus.busy), 0);
        end_commit("roll5");
        read_big("roll5_face5", 3'd5, 1);
        read_big("roll5_total", 3'd0, 1);

        // Pattern changes 10 cycles into the roll's end: commit slips by 10.
        start_roll(SEG_2);
        bus.dp_in = 1'b1;
        count_pulses(10, pulses);
        check("retarget_no_early", pulses, 0);
        bus.seg_in = SEG_6;
        wait_commit("retarget6", LAT, 3'd6);
        end_commit("retarget6");
        read_big("retarget_face2", 3'd2, 0);
        read_big("retarget_face6", 3'd6, 1);
        read_big("retarget_total", 3'd0, 2);

        // Invalid pattern counts as an error.
        start_roll(SEG_BAD);
        bus.dp_in = 1'b1;
        wait_commit("invalid", LAT, 3'd0);
        end_commit("invalid");
        read_big("invalid_err", 3'd7, 1);
        read_big("invalid_total", 3'd0, 3);
        read_big("invalid_face5", 3'd5, 1);
        read_big("invalid_face6", 3'd6, 1);

        // dp falls again while settling: only the second roll commits.
        do_reset();
        start_roll(SEG_4);
        bus.dp_in = 1'b1;
        step(8);
        bus.dp_in = 1'b0;
        count_pulses(12, pulses);
        check("reroll_no_commit", pulses, 0);
        check("reroll_busy", 32'(bus.busy), 1);
        bus.dp_in = 1'b1;
        wait_commit("reroll4", LAT, 3'd4);
        count_pulses(30, pulses);
        check("reroll_single_commit", pulses, 0);
        read_big("reroll_face4", 3'd4, 1);
        read_big("reroll_total", 3'd0, 1);

        // Saturation on the 4-bit instance, 17 rolls of face 3.
        do_reset();
        for (int r = 0; r < 17; r++) begin
            start_roll(SEG_3);
            bus.dp_in = 1'b1;
            wait_commit($sformatf("sat_roll%0d", r), LAT, 3'd3);
            end_commit($sformatf("sat_roll%0d", r));
        end
        read_small("sat_face3", 3'd3, 15);
        read_small("sat_total", 3'd0, 15);
        read_small("sat_err", 3'd7, 0);
        read_big("wide_face3", 3'd3, 17);

        // Clear coinciding with COMMIT: counters read 0, face still updates.
        start_roll(SEG_1);
        bus.dp_in = 1'b1;
        wait_commit("clr_roll", LAT, 3'd1);
        bus.clr = 1'b1;
        end_commit("clr_roll");
        bus.clr = 1'b0;
        check("clr_face_small", 32'(bus_s.face_out), 1);
        read_small("clr_small_total", 3'd0, 0);
        read_small("clr_small_face3", 3'd3, 0);
        read_small("clr_small_face1", 3'd1, 0);
        read_big("clr_big_total", 3'd0, 0);
        read_big("clr_big_face1", 3'd1, 0);
        check("clr_face_big", 32'(bus.face_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
